// File: rtl/eva_axi_rd_arb.sv
// eva_axi_rd_arb: round-robin AR arbiter for NUM_M read masters onto one AXI4
// read slave. The master index is prepended to ARID, and R beats are routed back
// by the RID upper bits. Each master has an outstanding-burst limit, and two
// sticky flags record protocol anomalies.
module eva_axi_rd_arb #(
  parameter int NUM_M    = 2,
  parameter int MID_W    = 2,
  parameter int MAX_OUTS = 4
) (
  input  logic                     aclk,
  input  logic                     arest_n,
  input  logic [NUM_M-1:0]         m_arvalid,
  input  logic [NUM_M*MID_W-1:0]   m_arid,
  input  logic [NUM_M*32-1:0]      m_araddr,
  input  logic [NUM_M*6-1:0]       m_arlen,
  output logic [NUM_M-1:0]         m_arready,
  output logic [NUM_M-1:0]         m_rvalid,
  output logic [MID_W-1:0]         m_rid,
  output logic [127:0]             m_rdata,
  output logic                     m_rlast,
  output logic [1:0]               m_rresp,
  input  logic [NUM_M-1:0]         m_rready,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  output logic [MID_W+1:0]         s_arid,
  output logic [31:0]              s_araddr,
  output logic [5:0]               s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  input  logic [MID_W+1:0]         s_rid,
  input  logic [127:0]             s_rdata,
  input  logic                     s_rlast,
  input  logic [1:0]               s_rresp,
  output logic                     err_unexp_id,
  output logic                     err_underflow
);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                        state_q;
  logic [1:0]                    rr_ptr_q;
  logic [NUM_M-1:0][CNT_W-1:0]   outs_q;
  logic                          s_arvalid_q;
  logic [MID_W+1:0]              s_arid_q;
  logic [31:0]                   s_araddr_q;
  logic [5:0]                    s_arlen_q;
  logic                          err_unexp_q, err_uf_q;

  logic [NUM_M-1:0] eligible, inc_v, dec_v;
  logic             grant_vld, ar_fire;
  logic [1:0]       grant_idx;
  logic [MID_W-1:0] win_id;
  logic [31:0]      win_addr;
  logic [5:0]       win_len;
  logic [1:0]       r_idx;
  logic             r_known, r_hs, r_done;

  // Eligibility, then the first eligible master after rr_ptr, with wrap-around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_M; i++)
      eligible[i] = m_arvalid[i] && (outs_q[i] < CNT_W'(MAX_OUTS));
    for (int k = 1; k <= NUM_M; k++)
      for (int i = 0; i < NUM_M; i++)
        if (!grant_vld && eligible[i] && ((int'(rr_ptr_q) + k) % NUM_M == i)) begin
          grant_vld = 1'b1;
          grant_idx = 2'(i);
        end
  end

  // A grant fires only in IDLE and outside reset. m_arready is combinational.
  assign ar_fire = arest_n && (state_q == IDLE) && grant_vld;

  // Winner payload mux and the one-hot accept.
  always_comb begin
    win_id   = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m_arready[i] = ar_fire && (grant_idx == 2'(i));
      if (grant_idx == 2'(i)) begin
        win_id   = m_arid[i*MID_W +: MID_W];
        win_addr = m_araddr[i*32 +: 32];
        win_len  = m_arlen[i*6 +: 6];
      end
    end
  end

  // R routing by the RID upper bits. Unknown masters are sunk so the slave never stalls.
  always_comb begin
    r_known  = 1'b0;
    s_rready = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      m_rvalid[i] = s_rvalid && (r_idx == 2'(i));
      if (r_idx == 2'(i)) begin
        r_known  = 1'b1;
        s_rready = m_rready[i];
      end
    end
  end

  assign r_idx   = s_rid[MID_W+1:MID_W];
  assign r_hs    = s_rvalid && s_rready;
  assign r_done  = r_hs && s_rlast;
  assign m_rid   = s_rid[MID_W-1:0];
  assign m_rdata = s_rdata;
  assign m_rlast = s_rlast;
  assign m_rresp = s_rresp;

  // Per-master increment (grant) and decrement (burst completion) strobes.
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      inc_v[i] = ar_fire && (grant_idx == 2'(i));
      dec_v[i] = r_done && (r_idx == 2'(i));
    end
  end

  // AR FSM: capture the winner into the one-deep slot, then hold it until the slave accepts.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'(NUM_M-1);
      s_arvalid_q <= 1'b0;
      s_arid_q    <= '0;
      s_araddr_q  <= '0;
      s_arlen_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_vld) begin
          s_arvalid_q <= 1'b1;
          s_arid_q    <= {grant_idx, win_id};
          s_araddr_q  <= win_addr;
          s_arlen_q   <= win_len;
          rr_ptr_q    <= grant_idx;
          state_q     <= SEND;
        end
        SEND: if (s_arready) begin
          s_arvalid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outstanding counters. A simultaneous grant and completion cancel out, and a
  // completion with nothing outstanding flags underflow without wrapping.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      outs_q   <= '0;
      err_uf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (inc_v[i] && !dec_v[i])
          outs_q[i] <= outs_q[i] + CNT_W'(1);
        else if (dec_v[i] && !inc_v[i]) begin
          if (outs_q[i] == '0) err_uf_q <= 1'b1;
          else                 outs_q[i] <= outs_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky flag for R beats addressed to a master index that does not exist.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n)                err_unexp_q <= 1'b0;
    else if (r_hs && !r_known)   err_unexp_q <= 1'b1;
  end

  assign s_arvalid     = s_arvalid_q;
  assign s_arid        = s_arid_q;
  assign s_araddr      = s_araddr_q;
  assign s_arlen       = s_arlen_q;
  assign s_arsize      = 3'b100;
  assign s_arburst     = 2'b01;
  assign err_unexp_id  = err_unexp_q;
  assign err_underflow = err_uf_q;

endmodule

// File: tb/tb_eva_axi_rd_arb.sv
// Bench for eva_axi_rd_arb. Directed scenarios are followed by a randomized run.
// A transaction-level model (grant search, outstanding counts, slave burst
// queue) predicts every output on every cycle.
module tb_eva_axi_rd_arb;
  localparam int NUM_M = 2, MID_W = 2, MAX_OUTS = 4;

  logic aclk = 1'b0, arest_n = 1'b0;
  logic [NUM_M-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NUM_M*MID_W-1:0] m_arid;
  logic [NUM_M*32-1:0] m_araddr;
  logic [NUM_M*6-1:0] m_arlen;
  logic [MID_W-1:0] m_rid;
  logic [127:0] m_rdata, s_rdata;
  logic m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [1:0] m_rresp, s_arburst, s_rresp;
  logic [3:0] s_arid, s_rid;
  logic [31:0] s_araddr;
  logic [5:0] s_arlen;
  logic [2:0] s_arsize;
  logic err_unexp_id, err_underflow;

  eva_axi_rd_arb #(.NUM_M(NUM_M), .MID_W(MID_W), .MAX_OUTS(MAX_OUTS)) dut (
    .aclk(aclk), .arest_n(arest_n),
    .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rresp(m_rresp), .m_rready(m_rready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rlast(s_rlast), .s_rresp(s_rresp),
    .err_unexp_id(err_unexp_id), .err_underflow(err_underflow)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model state.
  bit         slot_full;
  logic [3:0] e_id;
  logic [31:0] e_addr;
  logic [5:0] e_len;
  int         last_gnt;
  int         outs[NUM_M];
  int         gnt_cnt[NUM_M];
  bit         e_unexp, e_uf;
  logic [3:0] q_id[$];
  int         q_len[$];
  bit         r_hs;

  task automatic model_reset();
    slot_full = 0; last_gnt = NUM_M-1; e_unexp = 0; e_uf = 0;
    foreach (outs[i]) outs[i] = 0;
    q_id.delete(); q_len.delete();
  endtask

  task automatic idle_inputs();
    m_arvalid = '0; m_arid = '0; m_araddr = '0; m_arlen = '0; m_rready = '0;
    s_arready = 0; s_rvalid = 0; s_rid = '0; s_rdata = '0; s_rlast = 0; s_rresp = '0;
  endtask

  // One cycle: entered at negedge with inputs set; checks, then advances the model at posedge.
  task automatic cyc();
    int g, c, ridx, inc, dec;
    logic [NUM_M-1:0] exp_ardy, exp_rv;
    logic exp_srdy;
    #1;
    g = -1;
    for (int k = 1; k <= NUM_M; k++) begin
      c = (last_gnt + k) % NUM_M;
      if (g < 0 && ((m_arvalid >> c) & 1) != 0 && outs[c] < MAX_OUTS) g = c;
    end
    exp_ardy = (!slot_full && g >= 0) ? (NUM_M'(1) << g) : '0;
    chk("m_arready", m_arready, exp_ardy);
    chk("s_arvalid", s_arvalid, slot_full);
    if (slot_full) begin
      chk("s_arid", s_arid, e_id);
      chk("s_araddr", s_araddr, e_addr);
      chk("s_arlen", s_arlen, e_len);
    end
    chk("s_arsize", s_arsize, 3'b100);
    chk("s_arburst", s_arburst, 2'b01);
    ridx = int'(s_rid[3:2]);
    exp_rv = (s_rvalid && ridx < NUM_M) ? (NUM_M'(1) << ridx) : '0;
    exp_srdy = (ridx < NUM_M) ? (((m_rready >> ridx) & 1) != 0) : 1'b1;
    chk("m_rvalid", m_rvalid, exp_rv);
    chk("s_rready", s_rready, exp_srdy);
    chk("m_rid", m_rid, s_rid[1:0]);
    chk("m_rdata", m_rdata, s_rdata);
    chk("m_rlast", m_rlast, s_rlast);
    chk("m_rresp", m_rresp, s_rresp);
    chk("err_unexp", err_unexp_id, e_unexp);
    chk("err_uf", err_underflow, e_uf);
    r_hs = s_rvalid && exp_srdy;
    @(posedge aclk);
    inc = -1;
    if (slot_full) begin
      if (s_arready) begin
        q_id.push_back(e_id); q_len.push_back(int'(e_len)); slot_full = 0;
      end
    end else if (g >= 0) begin
      slot_full = 1;
      e_id = {2'(g), m_arid[g*MID_W +: MID_W]};
      e_addr = m_araddr[g*32 +: 32];
      e_len = m_arlen[g*6 +: 6];
      last_gnt = g; inc = g; gnt_cnt[g]++;
    end
    dec = (r_hs && s_rlast && ridx < NUM_M) ? ridx : -1;
    if (!(inc >= 0 && inc == dec)) begin
      if (inc >= 0) outs[inc]++;
      if (dec >= 0) begin
        if (outs[dec] == 0) e_uf = 1;
        else outs[dec]--;
      end
    end
    if (r_hs && ridx >= NUM_M) e_unexp = 1;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    arest_n = 0; m_arvalid = '1;
    #1;
    chk("rst_arvalid", s_arvalid, 1'b0);
    chk("rst_arready", m_arready, '0);
    chk("rst_arid", s_arid, '0);
    chk("rst_araddr", s_araddr, '0);
    chk("rst_arlen", s_arlen, '0);
    chk("rst_errs", {err_unexp_id, err_underflow}, 2'b00);
    @(negedge aclk);
    model_reset();
    idle_inputs();
    arest_n = 1;
  endtask

  int beat;
  bit r_busy, r_real;

  initial begin
    idle_inputs();
    model_reset();
    foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
    @(negedge aclk);
    do_reset();

    // First request: one cycle to s_arvalid with the master index prepended.
    m_arvalid = 2'b01; m_arid = 4'b0001; m_araddr = {32'h2000, 32'h1000}; m_arlen = {6'd1, 6'd3};
    cyc();
    chk("t1_arvalid", s_arvalid, 1'b1);
    chk("t1_arid", s_arid, 4'h1);
    chk("t1_araddr", s_araddr, 32'h1000);

    // Slave stalls for 5 cycles: payload is held and nothing else is accepted.
    m_arvalid = 2'b11; m_araddr = {32'h2000, 32'h5555};
    repeat (5) cyc();
    chk("stall_addr", s_araddr, 32'h1000);

    // Both masters requesting with a ready slave: grants alternate.
    s_arready = 1;
    foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
    repeat (12) cyc();
    chk("alt_g0", gnt_cnt[0], 3);
    chk("alt_g1", gnt_cnt[1], 3);

    // Master 0 is at its limit: it is blocked, while master 1 is still served.
    foreach (gnt_cnt[i]) gnt_cnt[i] = 0;
    m_arvalid = 2'b01;
    repeat (4) cyc();
    chk("max_block", gnt_cnt[0], 0);
    m_arvalid = 2'b11;
    repeat (2) cyc();
    chk("max_skip", gnt_cnt[1], 1);
    m_arvalid = 2'b00; s_rvalid = 1; s_rid = 4'h0; s_rlast = 1; m_rready = 2'b01;
    cyc();
    s_rvalid = 0; m_arvalid = 2'b01;
    repeat (2) cyc();
    chk("max_regrant", gnt_cnt[0], 1);

    // R back-pressure from master 1, then completion frees one slot.
    m_arvalid = 2'b00; s_rvalid = 1; s_rid = 4'h6; s_rlast = 1; m_rready = 2'b00;
    s_rdata = {4{32'hA5A5_0F0F}};
    repeat (3) begin
      cyc();
      chk("bp_srdy", s_rready, 1'b0);
    end
    m_rready = 2'b10;
    cyc();
    s_rvalid = 0; m_arvalid = 2'b10;
    repeat (2) cyc();
    chk("bp_dec", gnt_cnt[1], 2);

    // R beat for a master index that does not exist.
    m_arvalid = 2'b00; s_rvalid = 1; s_rid = 4'hC; m_rready = 2'b00;
    cyc();
    s_rvalid = 0;
    chk("unexp_flag", err_unexp_id, 1'b1);

    // Completion with nothing outstanding.
    do_reset();
    s_rvalid = 1; s_rid = 4'h0; s_rlast = 1; m_rready = 2'b01;
    cyc();
    s_rvalid = 0;
    chk("uf_flag", err_underflow, 1'b1);
    cyc();

    // Reset during SEND drops the slot, and master 0 has priority afterwards.
    do_reset();
    m_arvalid = 2'b10;
    repeat (2) cyc();
    chk("rs_pre", s_arvalid, 1'b1);
    #2 arest_n = 0;
    #1 chk("rs_arvalid", s_arvalid, 1'b0);
    model_reset();
    @(negedge aclk);
    arest_n = 1; m_arvalid = 2'b11;
    #1 chk("rs_prio", m_arready, 2'b01);
    cyc();

    // Randomized traffic against a well-behaved slave, with occasional bad-ID beats.
    do_reset();
    beat = 0; r_busy = 0; r_real = 0;
    repeat (2000) begin
      m_arvalid = NUM_M'($urandom);
      m_arid = 4'($urandom);
      m_araddr = {$urandom, $urandom};
      m_arlen = {6'($urandom % 4), 6'($urandom % 4)};
      s_arready = ($urandom % 3) != 0;
      m_rready = NUM_M'($urandom);
      if (!r_busy) begin
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_rresp = 2'($urandom);
        if (q_id.size() > 0 && ($urandom % 4) != 0) begin
          r_real = 1; r_busy = 1; s_rvalid = 1;
          s_rid = q_id[0]; s_rlast = (beat == q_len[0]);
        end else if (($urandom % 25) == 0) begin
          r_real = 0; r_busy = 1; s_rvalid = 1;
          s_rid = {2'(2 + $urandom % 2), 2'($urandom)}; s_rlast = 1'($urandom);
        end else begin
          s_rvalid = 0;
        end
      end
      cyc();
      if (r_hs) begin
        r_busy = 0;
        if (r_real) begin
          if (s_rlast) begin
            void'(q_id.pop_front()); void'(q_len.pop_front()); beat = 0;
          end else beat++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
